// File: rtl/hc85_seq_cascade_if.sv
// Handshake and operand bundle for hc85_seq_cascade.
// The requester drives START/operands/cascade inputs; the comparator returns status and result.
interface hc85_seq_cascade_if #(
    parameter int WIDTH = 16
) ();
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             IAGB;
    logic             IASB;
    logic             IAEB;
    logic             BUSY;
    logic             DONE;
    logic             QAGB;
    logic             QASB;
    logic             QAEB;

    modport master (
        output START, A, B, IAGB, IASB, IAEB,
        input  BUSY, DONE, QAGB, QASB, QAEB
    );

    modport slave (
        input  START, A, B, IAGB, IASB, IAEB,
        output BUSY, DONE, QAGB, QASB, QAEB
    );
endinterface

// File: rtl/hc85_seq_cascade.sv
// Nibble-serial HC85-style magnitude comparator, LSB nibble first, with cascade in/out.
// Define HC85_SIGNED_EN to treat operands as two's complement (MSB nibble compared signed).
module hc85_seq_cascade #(
    parameter int WIDTH = 16
) (
    input logic               CLK,
    input logic               RST_N,
    hc85_seq_cascade_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {C_EQ = 2'd0, C_GT = 2'd1, C_LT = 2'd2} casc_t;

    state_t           state, state_nxt;
    casc_t            casc, casc_nxt, casc_init, casc_step;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] a_q, b_q, a_sh, b_sh;
    logic [3:0]       a_nib, b_nib;
    logic             busy_q, busy_nxt, done_q, done_nxt;
    logic             load, last;
    logic [2:0]       q, q_nxt;  // {gt, lt, eq}

    assign load = (state == IDLE) && bus.START;
    assign last = (state == RUN) && (cnt == LAST);

    // Cascade inputs decode like a real HC85: IAEB wins, illegal 00/11 fall back to equal.
    always_comb begin
        casc_init = C_EQ;
        if (bus.IAEB)                   casc_init = C_EQ;
        else if (bus.IAGB && !bus.IASB) casc_init = C_GT;
        else if (!bus.IAGB && bus.IASB) casc_init = C_LT;
    end

    always_comb begin
        a_sh  = a_q >> {cnt, 2'b00};
        b_sh  = b_q >> {cnt, 2'b00};
        a_nib = a_sh[3:0];
        b_nib = b_sh[3:0];
`ifdef HC85_SIGNED_EN
        // Flipping the sign bit maps two's complement order onto unsigned order.
        if (cnt == LAST) begin
            a_nib[3] = ~a_nib[3];
            b_nib[3] = ~b_nib[3];
        end
`endif
        casc_step = casc;
        if (a_nib > b_nib)      casc_step = C_GT;
        else if (a_nib < b_nib) casc_step = C_LT;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.START) state_nxt = RUN;
            RUN:     if (last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt  = cnt;
        casc_nxt = casc;
        busy_nxt = busy_q;
        done_nxt = 1'b0;
        q_nxt    = q;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    cnt_nxt  = '0;
                    casc_nxt = casc_init;
                    busy_nxt = 1'b1;
                end
            end
            RUN: begin
                casc_nxt = casc_step;
                cnt_nxt  = last ? '0 : cnt + 1'b1;
                if (last) begin
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                    case (casc_step)
                        C_GT:    q_nxt = 3'b100;
                        C_LT:    q_nxt = 3'b010;
                        default: q_nxt = 3'b001;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= '0;
            casc   <= C_EQ;
            a_q    <= '0;
            b_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            q      <= 3'b001;
        end else begin
            cnt    <= cnt_nxt;
            casc   <= casc_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            q      <= q_nxt;
            if (load) begin
                a_q <= bus.A;
                b_q <= bus.B;
            end
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.QAGB = q[2];
    assign bus.QASB = q[1];
    assign bus.QAEB = q[0];
endmodule
